// File: rtl/f_alu_dispatch.sv
// f_alu_dispatch -- valid/ready front-end that holds FP ALU inputs for a settle window
// and returns the tagged result (rev 1.0)
`default_nettype none

module f_alu_dispatch #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [31:0] REQ_DATA1,
  input  logic [31:0] REQ_DATA2,
  input  logic [31:0] REQ_DATA3,
  input  logic [5:0]  REQ_SELECT,
  input  logic [4:0]  REQ_RD,
  output logic [31:0] ALU_DATA1,
  output logic [31:0] ALU_DATA2,
  output logic [31:0] ALU_DATA3,
  output logic [5:0]  ALU_SELECT,
  input  logic [31:0] ALU_RESULT,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic [31:0] RSP_RESULT,
  output logic [4:0]  RSP_RD,
  output logic        BUSY
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] alu_data1_q, alu_data1_d;
  logic [31:0] alu_data2_q, alu_data2_d;
  logic [31:0] alu_data3_q, alu_data3_d;
  logic [5:0]  alu_select_q, alu_select_d;
  logic [4:0]  tag_q, tag_d;
  logic [31:0] rsp_result_q, rsp_result_d;
  logic [4:0]  rsp_rd_q, rsp_rd_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        req_ready;
  logic        load;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    alu_data1_d  = alu_data1_q;
    alu_data2_d  = alu_data2_q;
    alu_data3_d  = alu_data3_q;
    alu_select_d = alu_select_q;
    tag_d        = tag_q;
    rsp_result_d = rsp_result_q;
    rsp_rd_d     = rsp_rd_q;
    rsp_valid_d  = rsp_valid_q;
    req_ready    = 1'b0;
    load         = 1'b0;

    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (REQ_VALID) begin
          load    = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rsp_result_d = ALU_RESULT;
          rsp_rd_d     = tag_q;
          rsp_valid_d  = 1'b1;
          state_d      = HOLD;
        end
      end
      HOLD: begin
        // Ready follows the consumer so a new op can issue on the response handshake edge
        req_ready = RSP_READY;
        if (RSP_READY) begin
          rsp_valid_d = 1'b0;
          if (REQ_VALID) begin
            load    = 1'b1;
            state_d = EXEC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      alu_data1_d  = REQ_DATA1;
      alu_data2_d  = REQ_DATA2;
      alu_data3_d  = REQ_DATA3;
      alu_select_d = REQ_SELECT;
      tag_d        = REQ_RD;
      cnt_d        = CNT_LOAD;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      alu_data1_q  <= 32'd0;
      alu_data2_q  <= 32'd0;
      alu_data3_q  <= 32'd0;
      alu_select_q <= 6'd0;
      tag_q        <= 5'd0;
      rsp_result_q <= 32'd0;
      rsp_rd_q     <= 5'd0;
      rsp_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      alu_data1_q  <= alu_data1_d;
      alu_data2_q  <= alu_data2_d;
      alu_data3_q  <= alu_data3_d;
      alu_select_q <= alu_select_d;
      tag_q        <= tag_d;
      rsp_result_q <= rsp_result_d;
      rsp_rd_q     <= rsp_rd_d;
      rsp_valid_q  <= rsp_valid_d;
    end
  end

  assign REQ_READY  = req_ready;
  assign ALU_DATA1  = alu_data1_q;
  assign ALU_DATA2  = alu_data2_q;
  assign ALU_DATA3  = alu_data3_q;
  assign ALU_SELECT = alu_select_q;
  assign RSP_VALID  = rsp_valid_q;
  assign RSP_RESULT = rsp_result_q;
  assign RSP_RD     = rsp_rd_q;
  assign BUSY       = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_f_alu_dispatch.sv
// tb_f_alu_dispatch -- scoreboard bench for f_alu_dispatch: instance 0 with a 4-cycle
// settle window, instance 1 with a 1-cycle window for back-to-back issue (rev 1.0)
`default_nettype none

module tb_f_alu_dispatch;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          acc;
  } exp_t;

  logic        clk;
  logic        rst        [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic [31:0] req_d1     [2];
  logic [31:0] req_d2     [2];
  logic [31:0] req_d3     [2];
  logic [5:0]  req_sel    [2];
  logic [4:0]  req_rd     [2];
  logic [31:0] alu_d1     [2];
  logic [31:0] alu_d2     [2];
  logic [31:0] alu_d3     [2];
  logic [5:0]  alu_sel    [2];
  logic [31:0] alu_res    [2];
  logic        rsp_valid  [2];
  logic        rsp_ready  [2];
  logic [31:0] rsp_result [2];
  logic [4:0]  rsp_rd     [2];
  logic        busy       [2];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int rsp_cnt [2] = '{0, 0};
  int issued  [2] = '{0, 0};
  bit rr_rand = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] cyc=%0d got %h expected %h", nm, g, cyc, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int SC = (g == 0) ? 4 : 1;

    f_alu_dispatch #(.SETTLE_CYCLES(SC)) u_dut (
      .CLK        (clk),
      .RESET      (rst[g]),
      .REQ_VALID  (req_valid[g]),
      .REQ_READY  (req_ready[g]),
      .REQ_DATA1  (req_d1[g]),
      .REQ_DATA2  (req_d2[g]),
      .REQ_DATA3  (req_d3[g]),
      .REQ_SELECT (req_sel[g]),
      .REQ_RD     (req_rd[g]),
      .ALU_DATA1  (alu_d1[g]),
      .ALU_DATA2  (alu_d2[g]),
      .ALU_DATA3  (alu_d3[g]),
      .ALU_SELECT (alu_sel[g]),
      .ALU_RESULT (alu_res[g]),
      .RSP_VALID  (rsp_valid[g]),
      .RSP_READY  (rsp_ready[g]),
      .RSP_RESULT (rsp_result[g]),
      .RSP_RD     (rsp_rd[g]),
      .BUSY       (busy[g])
    );

    // ALU stub: integer add of the first two operands
    assign alu_res[g] = alu_d1[g] + alu_d2[g];

    // Reference model: outstanding ops, last accepted operands, last delivered response
    exp_t        q[$];
    logic [31:0] m_d1, m_d2, m_d3, h_res;
    logic [5:0]  m_sel;
    logic [4:0]  h_rd;
    bit          live = 0;
    bit          ev, er;

    always @(negedge clk) begin
      ev = (q.size() > 0) && (cyc >= q[0].acc + SC);
      er = (q.size() == 0) || (ev && rsp_ready[g]);
      if (live) begin
        chk("rsp_valid", g, 32'(rsp_valid[g]), 32'(ev));
        chk("busy", g, 32'(busy[g]), 32'(q.size() > 0));
        chk("req_ready", g, 32'(req_ready[g]), 32'(er));
        chk("alu_data1", g, alu_d1[g], m_d1);
        chk("alu_data2", g, alu_d2[g], m_d2);
        chk("alu_data3", g, alu_d3[g], m_d3);
        chk("alu_select", g, 32'(alu_sel[g]), 32'(m_sel));
        if (ev) begin
          chk("rsp_result", g, rsp_result[g], q[0].res);
          chk("rsp_rd", g, 32'(rsp_rd[g]), 32'(q[0].rd));
        end else begin
          chk("rsp_result_idle", g, rsp_result[g], h_res);
          chk("rsp_rd_idle", g, 32'(rsp_rd[g]), 32'(h_rd));
        end
      end
      if (rst[g]) begin
        q.delete();
        m_d1 = '0; m_d2 = '0; m_d3 = '0; m_sel = '0;
        h_res = '0; h_rd = '0;
        live = 1;
      end else if (live) begin
        if (ev && rsp_ready[g]) begin
          h_res = q[0].res;
          h_rd  = q[0].rd;
          void'(q.pop_front());
          rsp_cnt[g]++;
        end
        if (req_valid[g] && er) begin
          q.push_back('{res: req_d1[g] + req_d2[g], rd: req_rd[g], acc: cyc + 1});
          m_d1 = req_d1[g]; m_d2 = req_d2[g]; m_d3 = req_d3[g]; m_sel = req_sel[g];
        end
      end
    end
  end

  task automatic step(input int g);
    @(posedge clk);
    #1;
    if (rr_rand) rsp_ready[g] = 1'($urandom_range(0, 1));
  endtask

  task automatic issue(input int g, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [5:0] s, input logic [4:0] r,
                       input bit keep, output int acc);
    bit hs;
    int n;
    req_d1[g] = a; req_d2[g] = b; req_d3[g] = c; req_sel[g] = s; req_rd[g] = r;
    req_valid[g] = 1'b1;
    hs = 0;
    n  = 0;
    while (!hs && n < 200) begin
      @(negedge clk);
      hs = req_ready[g];
      step(g);
      n++;
    end
    acc = cyc;
    if (!hs) chk("issue_timeout", g, 32'(n), 32'd0);
    else issued[g]++;
    if (!keep) req_valid[g] = 1'b0;
  endtask

  task automatic wait_valid(input int g, input int budget);
    int n;
    n = 0;
    while (!rsp_valid[g] && n < budget) begin
      step(g);
      n++;
    end
    if (!rsp_valid[g]) chk("rsp_timeout", g, 32'(n), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got timeout expected completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, prev;
    for (int g = 0; g < 2; g++) begin
      rst[g] = 1'b1; req_valid[g] = 1'b0; rsp_ready[g] = 1'b0;
      req_d1[g] = '0; req_d2[g] = '0; req_d3[g] = '0; req_sel[g] = '0; req_rd[g] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    rsp_ready[1] = 1'b1;
    while (cyc < 9) step(0);

    // Basic op accepted at edge 10, result visible after edge 14
    issue(0, 32'h3F800000, 32'h40000000, 32'h0, 6'h01, 5'd5, 0, acc);
    chk("accept_edge", 0, 32'(acc), 32'd10);
    wait_valid(0, 20);
    chk("rsp_edge", 0, 32'(cyc), 32'd14);
    chk("basic_result", 0, rsp_result[0], 32'h7F800000);
    chk("basic_rd", 0, 32'(rsp_rd[0]), 32'd5);

    // Back-pressure: second request waits behind a stalled response
    fork
      issue(0, 32'h12345678, 32'h01010101, 32'hAAAA5555, 6'h2A, 5'd17, 0, acc);
      begin
        repeat (6) begin
          step(0);
          chk("bp_result", 0, rsp_result[0], 32'h7F800000);
          chk("bp_req_ready", 0, 32'(req_ready[0]), 32'd0);
        end
        rsp_ready[0] = 1'b1;
      end
    join
    chk("bp_rsp_dropped", 0, 32'(rsp_valid[0]), 32'd0);
    chk("bp_busy", 0, 32'(busy[0]), 32'd1);
    repeat (8) step(0);

    // Input stability: request bus toggles while the op settles
    issue(0, $urandom, $urandom, $urandom, 6'h03, 5'd9, 0, acc);
    repeat (5) begin
      req_d1[0] = $urandom; req_d2[0] = $urandom; req_d3[0] = $urandom;
      req_sel[0] = 6'($urandom); req_rd[0] = 5'($urandom);
      step(0);
    end
    repeat (4) step(0);

    // Reset during the second EXEC cycle discards the op
    issue(0, 32'hDEADBEEF, 32'h00000001, 32'h0, 6'h05, 5'd30, 0, acc);
    step(0);
    rst[0] = 1'b1;
    step(0);
    rst[0] = 1'b0;
    chk("rst_busy", 0, 32'(busy[0]), 32'd0);
    chk("rst_valid", 0, 32'(rsp_valid[0]), 32'd0);
    chk("rst_alu1", 0, alu_d1[0], 32'd0);
    chk("rst_ready", 0, 32'(req_ready[0]), 32'd1);
    repeat (10) step(0);

    // Randomized traffic with random consumer back-pressure
    rr_rand = 1;
    for (int i = 0; i < 25; i++) begin
      bit keep;
      keep = 1'($urandom_range(0, 1));
      issue(0, $urandom, $urandom, $urandom, 6'($urandom), 5'($urandom), keep, acc);
      if (!keep) repeat ($urandom_range(0, 3)) step(0);
    end
    req_valid[0] = 1'b0;
    rr_rand = 0;
    rsp_ready[0] = 1'b1;
    repeat (12) step(0);

    // Back-to-back on the 1-cycle instance: one accept every 2 cycles
    prev = 0;
    for (int i = 0; i < 8; i++) begin
      issue(1, $urandom, $urandom, $urandom, 6'(i), 5'(i + 1), (i < 7), acc);
      if (i > 0) chk("b2b_gap", 1, 32'(acc - prev), 32'd2);
      prev = acc;
    end
    repeat (6) step(1);
    chk("b2b_count", 1, 32'(rsp_cnt[1]), 32'd8);
    chk("rsp_count", 0, 32'(rsp_cnt[0]), 32'(issued[0] - 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
